spatz_issue_ctrl: RTL and testbench



---
 rtl/spatz_issue_ctrl_if.sv | 43 ++++
 rtl/spatz_issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spatz_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spatz_issue_ctrl_if.sv
// Request, response and functional-unit dispatch signals of the Spatz issue controller.
// master: decoder/unit side; slave: the issue controller.
interface spatz_issue_ctrl_if #(
  parameter int unsigned ELEN    = 32,
  parameter int unsigned NrUnits = 2,
  parameter int unsigned UnitW   = (NrUnits > 1) ? $clog2(NrUnits) : 1
) ();
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [1:0]         req_csr_addr;
  logic [ELEN-1:0]    req_avl;
  logic [7:0]         req_vtype;
  logic [UnitW-1:0]   req_unit;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ELEN-1:0]    rsp_rd;

  logic [NrUnits-1:0] unit_valid;
  logic [NrUnits-1:0] unit_ready;
  logic [ELEN-1:0]    unit_vl;
  logic [ELEN-1:0]    unit_vtype;
  logic [NrUnits-1:0] unit_done;

  modport master (
    output req_valid, req_op, req_csr_addr, req_avl, req_vtype, req_unit,
    input  req_ready,
    input  rsp_valid, rsp_rd,
    output rsp_ready,
    input  unit_valid, unit_vl, unit_vtype,
    output unit_ready, unit_done
  );

  modport slave (
    input  req_valid, req_op, req_csr_addr, req_avl, req_vtype, req_unit,
    output req_ready,
    output rsp_valid, rsp_rd,
    input  rsp_ready,
    output unit_valid, unit_vl, unit_vtype,
    input  unit_ready, unit_done
  );
endinterface

// File: rtl/spatz_issue_ctrl.sv
// In-order issue controller: request FIFO, vector CSRs, vsetvl with drain, and
// dispatch to NrUnits functional units with per-unit outstanding-operation counters.
module spatz_issue_ctrl #(
  parameter int unsigned ELEN           = 32,
  parameter int unsigned VLEN           = 256,
  parameter int unsigned NrUnits        = 2,
  parameter int unsigned QueueDepth     = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spatz_issue_ctrl_if.slave ctrl_io,
  output logic              busy_o
);
  localparam int unsigned VLENB   = VLEN / 8;
  localparam int unsigned UnitW   = (NrUnits > 1) ? $clog2(NrUnits) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW    = $clog2(QueueDepth);
  localparam int unsigned VstartW = $clog2(VLEN);
  localparam logic [ELEN-1:0] VillOnly = {1'b1, {(ELEN-1){1'b0}}};

  typedef enum logic [1:0] {OpCsrRead = 2'd0, OpVsetvl = 2'd1, OpVexec = 2'd2, OpRsvd = 2'd3} op_e;
  typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StResp} state_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [1:0]       csr;
    logic [ELEN-1:0]  avl;
    logic [7:0]       vtype;
    logic [UnitW-1:0] unit;
  } req_t;

  state_e state_q, state_d;

  req_t            mem_q [QueueDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            full, empty, push, pop;
  req_t            head, req_in;

  logic [ELEN-1:0]    vl_q, vtype_q, rsp_rd_q;
  logic [VstartW-1:0] vstart_q;
  logic [CntW-1:0]    out_q [NrUnits];
  logic [CntW-1:0]    out_d [NrUnits];

  logic               rsp_valid, load_csr, load_vset, dispatch_acc, drained, any_out;
  logic               unit_ok, vexec_skip;
  logic [NrUnits-1:0] dispatch_valid;
  logic [ELEN-1:0]    csr_rd, new_vl, new_vtype, vlmax;
  logic [2:0]         vsew, vlmul;
  logic               set_illegal;

  assign full   = (cnt_q == (PtrW+1)'(QueueDepth));
  assign empty  = (cnt_q == '0);
  assign push   = ctrl_io.req_valid && !full;
  assign head   = mem_q[rptr_q];
  assign req_in = '{op: ctrl_io.req_op, csr: ctrl_io.req_csr_addr, avl: ctrl_io.req_avl,
                    vtype: ctrl_io.req_vtype, unit: ctrl_io.req_unit};

  assign unit_ok    = ({1'b0, head.unit} < (UnitW+1)'(NrUnits));
  assign vexec_skip = (vl_q == '0) || vtype_q[ELEN-1];

  // vsetvl result for the head entry; only consumed while draining.
  always_comb begin
    vsew        = head.vtype[5:3];
    vlmul       = head.vtype[2:0];
    set_illegal = (vsew > 3'd3) || ((32'd8 << vsew) > ELEN) || (vlmul > 3'd3);
    vlmax       = ELEN'((VLEN << vlmul[1:0]) >> (32'(vsew[1:0]) + 32'd3));
    new_vl      = '0;
    new_vtype   = '0;
    if (set_illegal) begin
      new_vtype[ELEN-1] = 1'b1;
    end else begin
      new_vl          = (head.avl < vlmax) ? head.avl : vlmax;
      new_vtype[7:0]  = head.vtype;
    end
  end

  always_comb begin
    unique case (head.csr)
      2'd0:    csr_rd = ELEN'(vstart_q);
      2'd1:    csr_rd = vl_q;
      2'd2:    csr_rd = vtype_q;
      default: csr_rd = ELEN'(VLENB);
    endcase
  end

  // Drain completes when every counter is zero after this cycle's done pulses.
  always_comb begin
    drained = 1'b1;
    any_out = 1'b0;
    for (int i = 0; i < NrUnits; i++) begin
      if (out_q[i] != '0) any_out = 1'b1;
      if (!((out_q[i] == '0) || ((out_q[i] == CntW'(1)) && ctrl_io.unit_done[i]))) begin
        drained = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          unique case (op_e'(head.op))
            OpCsrRead: state_d = StResp;
            OpVsetvl:  state_d = StDrain;
            OpVexec:   if (!vexec_skip) state_d = StDispatch;
            default:   state_d = StIdle;
          endcase
        end
      end
      StDispatch: if (pop) state_d = StIdle;
      StDrain:    if (drained) state_d = StResp;
      StResp:     if (ctrl_io.rsp_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    pop            = 1'b0;
    dispatch_valid = '0;
    dispatch_acc   = 1'b0;
    rsp_valid      = 1'b0;
    load_csr       = 1'b0;
    load_vset      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          unique case (op_e'(head.op))
            OpCsrRead: load_csr = 1'b1;
            OpVsetvl:  ;
            OpVexec:   pop = vexec_skip;
            default:   pop = 1'b1;
          endcase
        end
      end
      StDispatch: begin
        if (!unit_ok) begin
          pop = 1'b1;
        end else if (out_q[head.unit] != CntW'(MaxOutstanding)) begin
          dispatch_valid[head.unit] = 1'b1;
          if (ctrl_io.unit_ready[head.unit]) begin
            dispatch_acc = 1'b1;
            pop          = 1'b1;
          end
        end
      end
      StDrain: load_vset = drained;
      StResp: begin
        rsp_valid = 1'b1;
        pop       = ctrl_io.rsp_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NrUnits; i++) begin
      logic inc, dec;
      inc      = dispatch_acc && (head.unit == UnitW'(i));
      dec      = ctrl_io.unit_done[i] && (out_q[i] != '0);
      out_d[i] = out_q[i];
      if (inc && !dec)      out_d[i] = out_q[i] + CntW'(1);
      else if (dec && !inc) out_d[i] = out_q[i] - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= req_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      vl_q     <= '0;
      vtype_q  <= VillOnly;
      vstart_q <= '0;
      rsp_rd_q <= '0;
      for (int i = 0; i < NrUnits; i++) out_q[i] <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
      if (load_csr) rsp_rd_q <= csr_rd;
      if (load_vset) begin
        vl_q     <= new_vl;
        vtype_q  <= new_vtype;
        vstart_q <= '0;
        rsp_rd_q <= new_vl;
      end
      for (int i = 0; i < NrUnits; i++) out_q[i] <= out_d[i];
    end
  end

  assign ctrl_io.req_ready  = !full;
  assign ctrl_io.rsp_valid  = rsp_valid;
  assign ctrl_io.rsp_rd     = rsp_rd_q;
  assign ctrl_io.unit_valid = dispatch_valid;
  assign ctrl_io.unit_vl    = vl_q;
  assign ctrl_io.unit_vtype = vtype_q;
  assign busy_o = !empty || (state_q != StIdle) || any_out;

endmodule

// File: tb/tb_spatz_issue_ctrl.sv
// Directed bench for spatz_issue_ctrl with a response scoreboard and cycle-accurate checks.
module tb_spatz_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  spatz_issue_ctrl_if #(.ELEN(32), .NrUnits(2)) bus ();

  spatz_issue_ctrl #(
    .ELEN(32), .VLEN(256), .NrUnits(2), .QueueDepth(4), .MaxOutstanding(4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_io(bus),
    .busy_o (busy)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  bp_csr [5] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
  logic [31:0] bp_exp [5] = '{32'd256, 32'd32, 32'h3, 32'd256, 32'd32};
  int  acc, n, got, last;
  logic seen, take;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] csr, input logic [31:0] avl,
                      input logic [7:0] vt, input logic un, input bit has_rsp,
                      input logic [31:0] val);
    int k = 0;
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_csr_addr = csr;
    bus.req_avl      = avl;
    bus.req_vtype    = vt;
    bus.req_unit     = un;
    while (!bus.req_ready && k < 50) begin
      step();
      k++;
    end
    if (bus.req_ready) begin
      if (has_rsp) exp_q.push_back(val);
      step();
    end else begin
      chk("send_ready", 32'(bus.req_ready), 32'd1);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int k = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (bus.rsp_valid) begin
      if (exp_q.size() > 0) chk(tag, bus.rsp_rd, exp_q.pop_front());
      else chk({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
      step();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_dispatch(input int u, input string tag);
    int k = 0;
    while (!bus.unit_valid[u] && k < 50) begin
      step();
      k++;
    end
    chk(tag, 32'(bus.unit_valid[u]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_csr_addr = 2'd0; bus.req_avl = '0;
    bus.req_vtype = '0;   bus.req_unit = 1'b0; bus.rsp_ready = 1'b0;
    bus.unit_ready = '0;  bus.unit_done = '0;
    repeat (2) step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_unit_valid", 32'(bus.unit_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_rd", bus.rsp_rd, 32'd0);
    chk("rst_unit_vl", bus.unit_vl, 32'd0);
    chk("rst_unit_vtype", bus.unit_vtype, 32'h8000_0000);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    // Reset CSR values and CSR_READ latency.
    send(2'd0, 2'd1, 0, 0, 1'b0, 1'b1, 32'd0);
    chk("rd_lat_n1", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("rd_lat_n2", 32'(bus.rsp_valid), 32'd1);
    get_rsp("rd_vl");
    send(2'd0, 2'd2, 0, 0, 1'b0, 1'b1, 32'h8000_0000); get_rsp("rd_vtype");
    send(2'd0, 2'd3, 0, 0, 1'b0, 1'b1, 32'd32);        get_rsp("rd_vlenb");
    send(2'd0, 2'd0, 0, 0, 1'b0, 1'b1, 32'd0);         get_rsp("rd_vstart");

    // Legal vsetvl: SEW32 LMUL2 -> VLMAX 16.
    send(2'd1, 2'd0, 32'd100, 8'h11, 1'b0, 1'b1, 32'd16);
    chk("vset_n1", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("vset_n2", 32'(bus.rsp_valid), 32'd0);
    chk("vset_n2_vl", bus.unit_vl, 32'd0);
    step();
    chk("vset_n3", 32'(bus.rsp_valid), 32'd1);
    chk("vset_unit_vl", bus.unit_vl, 32'd16);
    chk("vset_unit_vtype", bus.unit_vtype, 32'h11);
    get_rsp("vset_legal");
    send(2'd0, 2'd2, 0, 0, 1'b0, 1'b1, 32'h11); get_rsp("rd_vtype_legal");

    // Single VEXEC dispatch latency and completion.
    bus.unit_ready = 2'b01;
    send(2'd2, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    chk("vexec_n1", 32'(bus.unit_valid), 32'd0);
    step();
    chk("vexec_n2", 32'(bus.unit_valid), 32'b01);
    step();
    chk("vexec_n3", 32'(bus.unit_valid), 32'd0);
    chk("vexec_busy", 32'(busy), 32'd1);
    bus.unit_done = 2'b01;
    step();
    bus.unit_done = 2'b00;
    chk("vexec_idle", 32'(busy), 32'd0);

    // Illegal vsetvl (SEW64 > ELEN) then a VEXEC that must be dropped.
    send(2'd1, 2'd0, 32'd50, 8'h18, 1'b0, 1'b1, 32'd0); get_rsp("vset_illegal");
    chk("ill_unit_vtype", bus.unit_vtype, 32'h8000_0000);
    chk("ill_unit_vl", bus.unit_vl, 32'd0);
    send(2'd0, 2'd2, 0, 0, 1'b0, 1'b1, 32'h8000_0000); get_rsp("rd_vtype_ill");
    send(2'd2, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    seen = 1'b0;
    repeat (6) begin
      seen = seen | (|bus.unit_valid);
      step();
    end
    chk("ill_no_dispatch", 32'(seen), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    bus.unit_ready = 2'b00;
    send(2'd1, 2'd0, 32'd100, 8'h11, 1'b0, 1'b1, 32'd16); get_rsp("vset_restore");

    // Drain ordering: two ops to unit 1, then vsetvl SEW8 LMUL1 avl 7.
    send(2'd2, 2'd0, 0, 0, 1'b1, 1'b0, 0);
    send(2'd2, 2'd0, 0, 0, 1'b1, 1'b0, 0);
    send(2'd1, 2'd0, 32'd7, 8'h00, 1'b0, 1'b1, 32'd7);
    repeat (3) begin
      chk("hold_u1", 32'(bus.unit_valid), 32'b10);
      step();
    end
    bus.unit_ready = 2'b10;
    step();
    wait_dispatch(1, "disp2_u1");
    step();
    bus.unit_ready = 2'b00;
    repeat (3) step();
    chk("drain_wait0", 32'(bus.rsp_valid), 32'd0);
    chk("drain_no_disp", 32'(bus.unit_valid), 32'd0);
    bus.unit_done = 2'b10;
    step();
    bus.unit_done = 2'b00;
    step();
    chk("drain_wait1", 32'(bus.rsp_valid), 32'd0);
    chk("drain_vl_old", bus.unit_vl, 32'd16);
    bus.unit_done = 2'b10;
    chk("drain_last", 32'(bus.rsp_valid), 32'd0);
    step();
    bus.unit_done = 2'b00;
    chk("drain_rise", 32'(bus.rsp_valid), 32'd1);
    chk("drain_vl_new", bus.unit_vl, 32'd7);
    get_rsp("vset_drain");

    // Dispatch accept and done on the same unit in one cycle keep the count at 1.
    bus.unit_ready = 2'b01;
    send(2'd2, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    wait_dispatch(0, "simA");
    step();
    send(2'd2, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    wait_dispatch(0, "simB");
    bus.unit_done = 2'b01;
    step();
    bus.unit_done = 2'b00;
    bus.unit_ready = 2'b00;
    send(2'd1, 2'd0, 32'd300, 8'h03, 1'b0, 1'b1, 32'd256);
    repeat (2) step();
    chk("sim_hold", 32'(bus.rsp_valid), 32'd0);
    bus.unit_done = 2'b01;
    step();
    bus.unit_done = 2'b00;
    chk("sim_rise", 32'(bus.rsp_valid), 32'd1);
    get_rsp("vset_sim");

    // Response backpressure fills the queue; responses then retire every 2 cycles.
    acc = 0;
    n   = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    while (acc < 4 && n < 20) begin
      bus.req_csr_addr = bp_csr[acc];
      if (bus.req_ready) begin
        exp_q.push_back(bp_exp[acc]);
        acc++;
      end
      step();
      n++;
    end
    bus.req_csr_addr = bp_csr[4];
    repeat (2) step();
    chk("bp_full", 32'(bus.req_ready), 32'd0);
    chk("bp_accepts", 32'(acc), 32'd4);
    bus.rsp_ready = 1'b1;
    got  = 0;
    last = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      take = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        if (exp_q.size() > 0) chk("bp_rd", bus.rsp_rd, exp_q.pop_front());
        if (got > 0) chk("bp_gap", 32'(c - last), 32'd2);
        last = c;
        got++;
      end
      if (take) exp_q.push_back(bp_exp[4]);
      step();
      if (take) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("bp_count", 32'(got), 32'd5);

    // Reset while draining with an operation outstanding.
    bus.unit_ready = 2'b01;
    send(2'd2, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    wait_dispatch(0, "rm_disp");
    step();
    bus.unit_ready = 2'b00;
    send(2'd1, 2'd0, 32'd5, 8'h00, 1'b0, 1'b0, 0);
    repeat (2) step();
    chk("rm_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rm_busy0", 32'(busy), 32'd0);
    chk("rm_vl", bus.unit_vl, 32'd0);
    chk("rm_vtype", bus.unit_vtype, 32'h8000_0000);
    chk("rm_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    bus.unit_done = 2'b01;
    step();
    bus.unit_done = 2'b00;
    step();
    chk("rm_late_done", 32'(busy), 32'd0);
    send(2'd0, 2'd1, 0, 0, 1'b0, 1'b1, 32'd0); get_rsp("rm_rd_vl");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
